// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_access_ctrl                                                 |
// | Purpose : Byte-addressed load/store initiator in front of DATA_MEM, with   |
// |           lane extraction on loads and read-modify-write on partial stores. |
// | Option  : DMEM_MISALIGN_TRAP_EN - trap misaligned requests via RESP_ERR.   |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dmem_access_ctrl #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [1:0]        REQ_SIZE,
  input  logic              REQ_SIGNED,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_WDATA,
  output logic              RESP_VALID,
  output logic [DATA_W-1:0] RESP_RDATA,
  output logic              RESP_ERR,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR_OUT,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_rd     = 3'd1;
  localparam logic [2:0] c_st_rmw_rd = 3'd2;
  localparam logic [2:0] c_st_wr     = 3'd3;
  localparam logic [2:0] c_st_resp   = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [2:0]        w_lowmask;
  logic              w_trap;
  logic [ADDR_W-1:0] w_cap_addr;
  logic [5:0]        w_shamt;
  logic [DATA_W-1:0] w_size_ones;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_ext;

  // Low address bits that must be zero for a naturally aligned access
  always_comb begin
    w_lowmask = 3'b000;
    case (REQ_SIZE)
      2'b00:   w_lowmask = 3'b000;
      2'b01:   w_lowmask = 3'b001;
      2'b10:   w_lowmask = 3'b011;
      default: w_lowmask = 3'b111;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_trap     = |(REQ_ADDR[2:0] & w_lowmask);
  assign w_cap_addr = REQ_ADDR;
`else
  assign w_trap     = 1'b0;
  assign w_cap_addr = {REQ_ADDR[ADDR_W-1:3], REQ_ADDR[2:0] & ~w_lowmask};
`endif

  assign w_shamt = {r_addr[2:0], 3'b000};

  always_comb begin
    w_size_ones = '0;
    case (r_size)
      2'b00:   w_size_ones = {{(DATA_W-8){1'b0}},  8'hFF};
      2'b01:   w_size_ones = {{(DATA_W-16){1'b0}}, 16'hFFFF};
      2'b10:   w_size_ones = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};
      default: w_size_ones = '1;
    endcase
  end

  // Lanes past the end of the doubleword shift out and are dropped
  assign w_mask    = w_size_ones << w_shamt;
  assign w_merged  = (MEM_RDATA & ~w_mask) | ((r_wdata << w_shamt) & w_mask);
  assign w_shifted = r_rdata >> w_shamt;

  always_comb begin
    w_ext = '0;
    case (r_size)
      2'b00:   w_ext = {{(DATA_W-8){r_signed & w_shifted[7]}},   w_shifted[7:0]};
      2'b01:   w_ext = {{(DATA_W-16){r_signed & w_shifted[15]}}, w_shifted[15:0]};
      2'b10:   w_ext = {{(DATA_W-32){r_signed & w_shifted[31]}}, w_shifted[31:0]};
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= c_st_idle;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: begin
        if (REQ_VALID) begin
          if (w_trap)                w_next = c_st_resp;
          else if (!REQ_WRITE)       w_next = c_st_rd;
          else if (REQ_SIZE == 2'b11) w_next = c_st_wr;
          else                       w_next = c_st_rmw_rd;
        end
      end
      c_st_rd:     w_next = c_st_resp;
      c_st_rmw_rd: w_next = c_st_wr;
      c_st_wr:     w_next = c_st_resp;
      c_st_resp:   w_next = c_st_idle;
      default:     w_next = c_st_idle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (REQ_VALID) begin
            r_write  <= REQ_WRITE;
            r_size   <= REQ_SIZE;
            r_signed <= REQ_SIGNED;
            r_err    <= w_trap;
            r_addr   <= w_cap_addr;
            r_wdata  <= REQ_WDATA;
          end
        end
        c_st_rd:     r_rdata <= MEM_RDATA;
        // Merged doubleword replaces the store data so WR drives one register
        c_st_rmw_rd: r_wdata <= w_merged;
        default: ;
      endcase
    end
  end

  assign MEM_ADDR_OUT = {3'b000, r_addr[ADDR_W-1:3]};

  always_comb begin
    REQ_READY  = 1'b0;
    MEM_READ   = 1'b0;
    MEM_WRITE  = 1'b0;
    MEM_WDATA  = '0;
    RESP_VALID = 1'b0;
    RESP_RDATA = '0;
    RESP_ERR   = 1'b0;
    case (r_state)
      c_st_idle:   REQ_READY = 1'b1;
      c_st_rd:     MEM_READ  = 1'b1;
      c_st_rmw_rd: MEM_READ  = 1'b1;
      c_st_wr: begin
        // A reset edge must never coincide with a committed write
        MEM_WRITE = ~RESET;
        MEM_WDATA = r_wdata;
      end
      c_st_resp: begin
        RESP_VALID = 1'b1;
        RESP_ERR   = r_err;
        RESP_RDATA = (r_write || r_err) ? '0 : w_ext;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dmem_access_ctrl                                              |
// | Purpose : Scoreboard bench for dmem_access_ctrl with a byte-level memory   |
// |           reference model; honours DMEM_MISALIGN_TRAP_EN when defined.      |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_WRITE = 1'b0;
  logic [1:0]  REQ_SIZE = 2'b00;
  logic        REQ_SIGNED = 1'b0;
  logic [63:0] REQ_ADDR = '0;
  logic [63:0] REQ_WDATA = '0;
  logic        REQ_READY, RESP_VALID, RESP_ERR, MEM_READ, MEM_WRITE;
  logic [63:0] RESP_RDATA, MEM_ADDR_OUT, MEM_WDATA, MEM_RDATA;

  always #5 CLK = ~CLK;

  dmem_access_ctrl #(.ADDR_W(64), .DATA_W(64)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA),
    .RESP_ERR(RESP_ERR), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR_OUT(MEM_ADDR_OUT), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  // DATA_MEM stand-in: 16 doublewords, combinational read
  logic [63:0] dmem [16];
  assign MEM_RDATA = dmem[MEM_ADDR_OUT[3:0]];
  always @(posedge CLK) if (MEM_WRITE) dmem[MEM_ADDR_OUT[3:0]] <= MEM_WDATA;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  refm [128];
  int          total = 0;
  int          bad = 0;
  int          exp_idx = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%016h want 0x%016h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] ref_load(input int a, input int sz, input bit sg);
    int nb = 1 << sz;
    int base = a & ~7;
    int off = a & 7;
    logic [63:0] v = '0;
    logic [63:0] m;
    for (int i = 0; i < nb; i++)
      if (off + i < 8) v[8*i +: 8] = refm[base + off + i];
    if (sg && nb < 8 && v[8*nb-1]) begin
      m = (64'd1 << (8*nb)) - 64'd1;
      v = v | ~m;
    end
    return v;
  endfunction

  task automatic ref_store(input int a, input int nb, input logic [63:0] wd);
    for (int i = 0; i < nb; i++)
      if ((a & 7) + i < 8) refm[a + i] = wd[8*i +: 8];
  endtask

  // Presents a request; returns at the negedge after it was accepted
  task automatic issue(input bit wr, input bit [1:0] sz, input bit sg, input int a,
                       input logic [63:0] wd, input bit abort);
    int n = 0;
    int nb = 1 << sz;
    int ea;
    bit mis;
    exp_t e;
    REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_SIZE = sz; REQ_SIGNED = sg;
    REQ_ADDR = 64'(a); REQ_WDATA = wd;
    while (!REQ_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) begin
      total++; bad++;
      $display("FAIL accept_timeout: got ready=0 want ready=1 after %0d cycles", n);
      REQ_VALID = 1'b0;
      return;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (a & (nb - 1)) != 0;
    ea  = a;
`else
    mis = 1'b0;
    ea  = a & ~(nb - 1);
`endif
    exp_idx = ea >> 3;
    e.cyc   = cyc + (mis ? 1 : ((wr && sz != 2'b11) ? 3 : 2));
    e.err   = mis;
    e.rdata = '0;
    if (!mis) begin
      if (wr) begin
        if (!abort) ref_store(ea, nb, wd);
      end else begin
        e.rdata = ref_load(ea, sz, sg);
      end
    end
    if (!abort) q.push_back(e);
    @(negedge CLK);
  endtask

  // Byte store aborted by a reset pulse in RMW_RD (stage 0) or WR (stage 1)
  task automatic abort_store(input int stage, input int a);
    issue(1'b1, 2'b00, 1'b0, a, 64'h5A, 1'b1);
    REQ_VALID = 1'b0;
    repeat (stage) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("abort_ready", 64'(REQ_READY), 64'd1);
    chk("abort_no_write", 64'(MEM_WRITE), 64'd0);
    repeat (3) @(negedge CLK);
    issue(1'b0, 2'b11, 1'b0, a & ~7, '0, 1'b0);
  endtask

  // Monitor: strobe sanity every cycle, scoreboard pop on each response
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (MEM_READ || MEM_WRITE) begin
          chk("strobe_excl", 64'(MEM_READ & MEM_WRITE), 64'd0);
          chk("mem_addr", MEM_ADDR_OUT, 64'(exp_idx));
        end
        if (RESP_VALID) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: got RESP_VALID=1 want 0 (cyc %0d)", cyc);
          end else begin
            e = q.pop_front();
            chk("resp_rdata", RESP_RDATA, e.rdata);
            chk("resp_err", 64'(RESP_ERR), 64'(e.err));
            chk("resp_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish by 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [63:0] v;
    for (int i = 0; i < 128; i++) refm[i] = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ready", 64'(REQ_READY), 64'd1);
    chk("rst_resp_valid", 64'(RESP_VALID), 64'd0);
    chk("rst_resp_err", 64'(RESP_ERR), 64'd0);
    chk("rst_resp_rdata", RESP_RDATA, 64'd0);
    chk("rst_mem_read", 64'(MEM_READ), 64'd0);
    chk("rst_mem_write", 64'(MEM_WRITE), 64'd0);
    chk("rst_mem_addr", MEM_ADDR_OUT, 64'd0);
    chk("rst_mem_wdata", MEM_WDATA, 64'd0);
    RESET = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 16; i++) issue(1'b1, 2'b11, 1'b0, i * 8, {$urandom, $urandom}, 1'b0);

    issue(1'b1, 2'b11, 1'b0, 8, 64'h3, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 8, '0, 1'b0);
    issue(1'b1, 2'b11, 1'b0, 0, 64'h80FF, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 1, '0, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 1, '0, 1'b0);
    issue(1'b1, 2'b11, 1'b0, 0, 64'h1122334455667788, 1'b0);
    issue(1'b1, 2'b01, 1'b0, 2, 64'hFFFF_0000_0000_BEEF, 1'b0);
    issue(1'b0, 2'b11, 1'b0, 0, '0, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 6, '0, 1'b0);
    issue(1'b0, 2'b10, 1'b1, 0, '0, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 4, '0, 1'b0);
    REQ_VALID = 1'b0;
    @(negedge CLK);

    abort_store(0, 8'h13);
    abort_store(1, 8'h26);

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        REQ_VALID = 1'b0;
        @(negedge CLK);
      end
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 127)), {$urandom, $urandom}, 1'b0);
    end
    REQ_VALID = 1'b0;

    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 16; i++) begin
      for (int b = 0; b < 8; b++) v[8*b +: 8] = refm[i*8 + b];
      chk($sformatf("final_mem[%0d]", i), dmem[i], v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
